// File: rtl/drive_pkg.sv
// Shared types and widths for the drive motion controller.
package drive_pkg;

  localparam int CNT_W  = 24;
  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } state_e;

endpackage

// File: rtl/drive_pwm.sv
// PWM generator: prescaled 8-bit counter. The applied duty only changes on the
// 255->0 wrap so a period is never cut short, except that force_zero kills it at once.
module drive_pwm
  import drive_pkg::*;
#(
  parameter int PWM_DIV = 4
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              force_zero,
  output logic              pwm_out
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] applied_q, applied_d;
  logic              pre_tick;

  // Prescaler, counter advance and period-boundary reload of the applied duty
  always_comb begin
    pre_tick  = (pre_q == PRE_W'(PWM_DIV - 1));
    pre_d     = pre_tick ? '0 : pre_q + PRE_W'(1);
    cnt_d     = pre_tick ? cnt_q + DUTY_W'(1) : cnt_q;
    applied_d = applied_q;
    if (force_zero) begin
      applied_d = '0;
    end else if (pre_tick && (cnt_q == '1)) begin
      applied_d = duty_in;
    end
  end

  // PWM state registers; reset clears the applied duty so the pin drops immediately
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      applied_q <= '0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      applied_q <= applied_d;
    end
  end

  assign pwm_out = (cnt_q < applied_q);

endmodule

// File: rtl/drive_motion_ctrl.sv
// Move-command motion controller: trapezoidal duty profile over encoder distance.
// Optional stall detection is compiled in with DRIVE_STALL_DETECT_EN.
module drive_motion_ctrl
  import drive_pkg::*;
#(
  parameter int PWM_DIV      = 4,
  parameter int RAMP_DIV     = 1000,
  parameter int RAMP_STEP    = 8,
  parameter int MIN_DUTY     = 32,
  parameter int DECEL_DIST   = 200,
  parameter int STALL_CYCLES = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_dist,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic [CNT_W-1:0]  enc_count,
  input  logic              abort,
  output logic              MotorDirection,
  output logic              MotorPWM,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  localparam int RAMP_W = $clog2(RAMP_DIV + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  start_q, start_d, dist_q, dist_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d, duty_q, duty_d;
  logic              dir_q, dir_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;

  logic [CNT_W-1:0]  diff, traveled, remaining;
  logic [DUTY_W-1:0] duty_floor;
  logic              moving, arrived, near_end, ramp_tick, force_zero, stall_hit;

  function automatic logic [DUTY_W-1:0] step_up(input logic [DUTY_W-1:0] cur,
                                                input logic [DUTY_W-1:0] lim);
    logic [DUTY_W+1:0] sum;
    sum = {2'b00, cur} + (DUTY_W + 2)'(RAMP_STEP);
    if (sum >= {2'b00, lim}) return lim;
    return sum[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] flr);
    if ({2'b00, cur} >= ({2'b00, flr} + (DUTY_W + 2)'(RAMP_STEP)))
      return cur - DUTY_W'(RAMP_STEP);
    if (cur > flr) return flr;
    return cur;
  endfunction

  // Distance bookkeeping; a negative signed difference means no progress yet
  always_comb begin
    moving     = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);
    diff       = dir_q ? (enc_count - start_q) : (start_q - enc_count);
    traveled   = diff[CNT_W-1] ? '0 : diff;
    arrived    = (traveled >= dist_q);
    remaining  = dist_q - traveled;
    near_end   = (remaining <= CNT_W'(DECEL_DIST));
    ramp_tick  = (ramp_q == RAMP_W'(RAMP_DIV - 1));
    duty_floor = (tgt_q < DUTY_W'(MIN_DUTY)) ? tgt_q : DUTY_W'(MIN_DUTY);
  end

`ifdef DRIVE_STALL_DETECT_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  logic [CNT_W-1:0]   prev_enc_q, prev_enc_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  // Count consecutive moving cycles during which the encoder has not changed
  always_comb begin
    prev_enc_d = enc_count;
    stall_d    = '0;
    stall_hit  = 1'b0;
    if (moving && (enc_count == prev_enc_q)) begin
      if (stall_q == STALL_W'(STALL_CYCLES - 1)) stall_hit = 1'b1;
      else                                       stall_d   = stall_q + STALL_W'(1);
    end
  end

  // Stall detector registers
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      prev_enc_q <= '0;
      stall_q    <= '0;
    end else begin
      prev_enc_q <= prev_enc_d;
      stall_q    <= stall_d;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Next-state, duty profile and status outputs
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    dist_d     = dist_q;
    dir_d      = dir_q;
    tgt_d      = tgt_q;
    duty_d     = duty_q;
    ramp_d     = ramp_tick ? '0 : ramp_q + RAMP_W'(1);
    force_zero = 1'b0;
    cmd_ready  = 1'b0;
    busy       = moving;
    done       = 1'b0;
    fault      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        duty_d    = '0;
        ramp_d    = '0;
        if (cmd_valid) begin
          start_d = enc_count;
          dist_d  = cmd_dist;
          dir_d   = cmd_dir;
          tgt_d   = cmd_duty;
          state_d = (cmd_dist == '0) ? DONE : ACCEL;
        end
      end
      ACCEL, CRUISE, DECEL: begin
        if (abort) begin
          state_d    = IDLE;
          duty_d     = '0;
          force_zero = 1'b1;
        end else if (arrived) begin
          state_d    = DONE;
          duty_d     = '0;
          force_zero = 1'b1;
        end else if (stall_hit) begin
          state_d    = FAULT;
          duty_d     = '0;
          force_zero = 1'b1;
        end else begin
          if (ramp_tick && (state_q == ACCEL)) duty_d = step_up(duty_q, tgt_q);
          if (ramp_tick && (state_q == DECEL)) duty_d = step_down(duty_q, duty_floor);
          if (near_end)                                   state_d = DECEL;
          else if ((state_q == ACCEL) && (duty_d == tgt_q)) state_d = CRUISE;
        end
      end
      DONE: begin
        done    = !abort;
        duty_d  = '0;
        state_d = IDLE;
      end
      FAULT: begin
        fault  = 1'b1;
        duty_d = '0;
        if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b1;
      ramp_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      ramp_q  <= ramp_d;
    end
  end

  // Latched command data; only meaningful while a move is in progress
  always_ff @(posedge CLOCK_50) begin
    start_q <= start_d;
    dist_q  <= dist_d;
    tgt_q   <= tgt_d;
  end

  drive_pwm #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .duty_in    (duty_q),
    .force_zero (force_zero),
    .pwm_out    (MotorPWM)
  );

  assign MotorDirection = dir_q;

endmodule

// File: tb/tb_drive_motion_ctrl.sv
// Scoreboard bench for drive_motion_ctrl: expected done events are queued at
// command issue and checked by a monitor whenever the DUT pulses done.
module tb_drive_motion_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_dist = '0;
  logic        cmd_dir = 1'b1;
  logic [7:0]  cmd_duty = '0;
  logic [23:0] enc_count = '0;
  logic        abort = 1'b0;
  logic        MotorDirection, MotorPWM, busy, done, fault;

  drive_motion_ctrl #(
    .PWM_DIV      (1),
    .RAMP_DIV     (10),
    .RAMP_STEP    (8),
    .MIN_DUTY     (32),
    .DECEL_DIST   (200),
    .STALL_CYCLES (100)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dist       (cmd_dist),
    .cmd_dir        (cmd_dir),
    .cmd_duty       (cmd_duty),
    .enc_count      (enc_count),
    .abort          (abort),
    .MotorDirection (MotorDirection),
    .MotorPWM       (MotorPWM),
    .busy           (busy),
    .done           (done),
    .fault          (fault)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic        dir;
    logic [23:0] enc;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  logic done_prev = 1'b0;
  int   hi;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic expect_done(input logic dir, input logic [23:0] enc, input int lat);
    exp_t e;
    e.dir = dir; e.enc = enc; e.lat = lat; e.acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [23:0] d, input logic dr, input logic [7:0] du);
    check("cmd_ready_before_accept", cmd_ready, 1);
    cmd_dist = d; cmd_dir = dr; cmd_duty = du; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic walk_enc(input logic [23:0] to, input logic up, input int hold);
    while (enc_count != to) begin
      repeat (hold) tick();
      enc_count = up ? enc_count + 24'd1 : enc_count - 24'd1;
    end
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge CLOCK_50);
      h += int'(MotorPWM);
    end
  endtask

  // Done monitor: every pulse must match the oldest queued expectation
  always @(negedge CLOCK_50) begin : mon
    exp_t e;
    if (rst_n && done) begin
      check("done_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("done_enc", enc_count, e.enc);
        check("done_dir", MotorDirection, e.dir);
        check("done_pwm_zero", MotorPWM, 0);
        check("done_busy_low", busy, 0);
        if (e.lat >= 0) check("done_latency", cyc - e.acc, e.lat);
      end
      check("done_single_cycle", done_prev, 0);
    end
    done_prev <= done;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_total);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_pwm", MotorPWM, 0);
    check("rst_dir", MotorDirection, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    rst_n = 1'b1;
    tick();
    check("rst_cmd_ready", cmd_ready, 1);

    // Full trapezoid move: start 100, forward 1000, cruise duty 200
    enc_count = 24'd100;
    expect_done(1'b1, 24'd1100, -1);
    send_cmd(24'd1000, 1'b1, 8'd200);
    check("move_busy", busy, 1);
    check("move_cmd_ready_low", cmd_ready, 0);
    check("move_dir", MotorDirection, 1);
    fork
      walk_enc(24'd900, 1'b1, 2);
      begin
        repeat (600) @(negedge CLOCK_50);
        count_high(256, hi);
        check("cruise_pwm_high_count", hi, 200);
      end
    join
    fork
      walk_enc(24'd1100, 1'b1, 4);
      begin
        repeat (520) @(negedge CLOCK_50);
        count_high(256, hi);
        check("decel_floor_high_count", hi, 32);
      end
    join
    repeat (3) tick();
    check("after_done_busy", busy, 0);
    check("after_done_ready", cmd_ready, 1);
    count_high(300, hi);
    check("after_done_pwm_quiet", hi, 0);

    // Zero-distance command completes straight away without driving the motor
    tick();
    expect_done(1'b1, 24'd1100, 1);
    send_cmd(24'd0, 1'b1, 8'd100);
    count_high(20, hi);
    check("zero_dist_pwm_quiet", hi, 0);
    tick();
    check("zero_dist_ready", cmd_ready, 1);

    // Reverse move across the 24-bit wrap: 5 down to 0xFFFFF1
    enc_count = 24'd5;
    expect_done(1'b0, 24'hFFFFF1, -1);
    send_cmd(24'd20, 1'b0, 8'd150);
    check("rev_dir_moving", MotorDirection, 0);
    walk_enc(24'hFFFFF1, 1'b0, 1);
    check("rev_dir_at_end", MotorDirection, 0);
    repeat (4) tick();
    check("rev_dir_held_idle", MotorDirection, 0);
    check("rev_idle_ready", cmd_ready, 1);

    // Abort during cruise
    enc_count = 24'd0;
    send_cmd(24'd5000, 1'b1, 8'd64);
    fork
      walk_enc(24'd400, 1'b1, 2);
      begin
        repeat (500) @(negedge CLOCK_50);
        count_high(256, hi);
        check("cruise64_high_count", hi, 64);
      end
    join
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_pwm", MotorPWM, 0);
    check("abort_no_done", done, 0);
    count_high(300, hi);
    check("abort_pwm_quiet", hi, 0);

    // Abort and arrival in the same cycle: abort wins, no done pulse
    tick();
    send_cmd(24'd10, 1'b1, 8'd64);
    enc_count = 24'd410;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_arrive_ready", cmd_ready, 1);
    check("abort_arrive_done", done, 0);
    repeat (5) tick();

    // Frozen encoder while moving
    send_cmd(24'd1000, 1'b1, 8'd128);
`ifdef DRIVE_STALL_DETECT_EN
    repeat (99) tick();
    check("stall_not_yet", fault, 0);
    tick();
    check("stall_fault", fault, 1);
    check("stall_busy", busy, 0);
    check("stall_pwm", MotorPWM, 0);
    check("stall_ready_low", cmd_ready, 0);
    repeat (5) tick();
    check("stall_fault_sticky", fault, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("stall_cleared", fault, 0);
    check("stall_ready", cmd_ready, 1);
`else
    repeat (300) tick();
    check("nostall_fault", fault, 0);
    check("nostall_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("nostall_abort_ready", cmd_ready, 1);
`endif

    // Asynchronous reset while accelerating
    tick();
    send_cmd(24'd1000, 1'b1, 8'd255);
    for (int i = 0; i < 330 && !MotorPWM; i++) begin
      tick();
      enc_count = enc_count + 24'd1;
    end
    check("accel_pwm_high", MotorPWM, 1);
    check("accel_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", MotorPWM, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_dir", MotorDirection, 1);
    check("async_rst_fault", fault, 0);
    check("async_rst_done", done, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
